genesis_pad_port: RTL and testbench
===================================

# genesis_pad_port

Console-side gamepad port model. Consumes the decoded button word and detected pad type produced by `genesis_gamepad`. Re-serialises them onto the 6-pin data lines that the Genesis core's I/O port samples, driven by the core's TH/select output. It emulates Master System, 3-button and 6-button pad protocols, including the 6-button TH-edge sequence and its 1.5 ms reset timeout.

## Interface
- `TIMEOUT_CYCLES`, 75000, iCLK cycles without a TH falling edge before the 6-button sequence restarts (1.5 ms at 50 MHz).
- `iCLK` input 1: 50 MHz clock; one clock domain.
- `iRST_N` input 1: synchronous, active-low reset.
- `iPAD_TYPE` input 2: 00 Master System, 01 3-button, 10 6-button, 11 no pad.
- `iBUTTONS` input 12: {Z,Y,X,M,S,C,B,A,U,D,L,R}, active-high pressed.
- `iTH` input 1: console TH/select line, same clock domain.
- `oPAD_DATA` output 6: {C/Start, B/A, Up/Z, Down/Y, Left/X, Right/Mode}, active-low, registered.
- `oPHASE` output 3: current protocol state 0..7, registered, for debug and verification.

## Operation
- **TH edge detection**
  - `th_q` is the registered `iTH`.
  - Falling edge = `th_q`=1 and `iTH`=0.
  - Rising edges are not counted.
- **Falling-edge counter `cnt`** (2 bits)
  - Increments on each TH falling edge and wraps 3→0.
  - Used only when `iPAD_TYPE`=10; held at 0 for every other type.
- **State mapping, `oPHASE`**
  - TH=1: `cnt` 0/1/2/3 → state 0/2/4/6.
  - TH=0: `cnt` 1/2/3/0 → state 1/3/5/7.
- **Output selection**, computed from the updated `cnt` and current `iTH`. `~` means the output is the active-low inverse.
  - Type 00: `~{B6,B5,U,D,L,R}`, independent of TH. `oPHASE`=0.
  - Type 01, TH=1: `~{C,B,U,D,L,R}`.
  - Type 01, TH=0: `~{S,A,U,D,1,1}`. L and R read as pressed; this is the 3-button signature.
  - Type 10, states 0/2/4: as type 01 with TH=1.
  - Type 10, states 1/3: as type 01 with TH=0.
  - Type 10, state 5: `~{S,A,1,1,1,1}`. The D-pad reads as fully pressed.
  - Type 10, state 6: `~{0,0,Z,Y,X,M}`.
  - Type 10, state 7: `~{S,A,0,0,0,0}`. The D-pad reads as released.
  - Type 11: 6'h3F.
- **Timeout**
  - The timer clears on each TH falling edge; otherwise it increments and saturates at `TIMEOUT_CYCLES`.
  - Expiry happens on the `TIMEOUT_CYCLES`-th consecutive cycle with no falling edge, i.e. the cycle where the timer equals `TIMEOUT_CYCLES`-1.
  - At expiry, `cnt` ← 0 if `iTH`=1, or `cnt` ← 1 if `iTH`=0. This keeps the pad in a normal 3-button state.
  - Expiry acts once; later saturated cycles change nothing.
  - Timer width: `$clog2(TIMEOUT_CYCLES+1)`.
- **Boundary cases**
  - Falling edge in the same cycle as expiry: the edge wins. `cnt` increments and the timer clears.
  - Any change of `iPAD_TYPE` (registered compare): `cnt` ← 0 and the timer clears in that cycle. The output follows the new type in the same cycle.
  - Button changes mid-sequence are reflected in the next output register update; buttons are not latched per sequence.

## Timing
- Reset values while `iRST_N`=0 (sampled on `iCLK` rising edge):
  - `oPAD_DATA`=6'h3F, `oPHASE`=0.
  - `cnt`=0, timer=0, `th_q`=1, registered type=11.
  - `iTH` edges during reset are ignored.
- Latency: `oPAD_DATA` and `oPHASE` reflect an `iTH`, `iBUTTONS` or `iPAD_TYPE` change exactly 1 clock after it is sampled.
- First cycle after reset release: a falling edge is detected only if `iTH` is sampled 0 there, since `th_q` resets to 1.
- Reset asserted mid-sequence returns all state to reset values on the next clock edge.
- No handshake: the core samples `oPAD_DATA` at will.
- The console must hold TH ≥2 cycles per level.

## Test plan
1. **Reset:** assert `iRST_N`=0 for 3 cycles while toggling `iTH` → `oPAD_DATA`=6'h3F and `oPHASE`=0 throughout, and 1 cycle after release with type 11.
2. **Master System:** type 00, `iBUTTONS`=12'h061, toggle TH → `oPAD_DATA`=6'b001110 constant and `oPHASE`=0.
3. **3-button:** type 01, `iBUTTONS`=12'h098.
   - TH=1 → 6'b110111.
   - TH=0 → 6'b000100, appearing 1 cycle after the TH change.
   - Four pulses → `oPHASE` stays in {0..3} mapping, not 5/6/7 outputs.
4. **6-button sequence:** type 10, `iBUTTONS`=12'h900, four TH low pulses of 10 cycles → `oPHASE` steps 0,1,2,3,4,5,6,7.
   - State 6 → 6'b110110.
   - State 5 → 6'b110000.
   - State 7 → 6'b111111.
   - A fifth falling edge → state 1.
5. **Timeout:**
   - Two pulses, then TH held high for 74999 cycles → still state 4.
   - Cycle 75000 → state 0.
   - Repeat with TH held low after edge 3 → state 5 becomes state 1.
6. **Conflicts:**
   - Falling edge exactly on the expiry cycle → `cnt` increments, not cleared.
   - Change type 10→01 at state 5 → `oPHASE`=1 and `oPAD_DATA` uses the 3-button TH=0 map next cycle.

Source files
------------

// File: rtl/genesis_pad_port.sv
// genesis_pad_port
// Console-side gamepad port model. Takes the decoded button word and pad
// type from genesis_gamepad and re-serialises them onto the six active-low
// data lines that the Genesis I/O port samples, steered by the console's
// TH/select line. Supports the Master System, 3-button and 6-button
// protocols, including the 6-button TH falling-edge sequence and its
// inactivity timeout.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles without a TH falling edge before the 6-button
//                   sequence falls back to a plain 3-button state
// Ports:
//   iCLK       clock (single domain)
//   iRST_N     synchronous active-low reset
//   iPAD_TYPE  00 Master System, 01 3-button, 10 6-button, 11 no pad
//   iBUTTONS   {Z,Y,X,M,S,C,B,A,U,D,L,R}, active-high pressed
//   iTH        console TH/select line
//   oPAD_DATA  {C/Start, B/A, Up/Z, Down/Y, Left/X, Right/Mode}, active-low
//   oPHASE     current protocol state 0..7 (debug)
module genesis_pad_port #(
  parameter int TIMEOUT_CYCLES = 75000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [1:0]  iPAD_TYPE,
  input  logic [11:0] iBUTTONS,
  input  logic        iTH,
  output logic [5:0]  oPAD_DATA,
  output logic [2:0]  oPHASE
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX  = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    PAD_SMS  = 2'b00,
    PAD_3BTN = 2'b01,
    PAD_6BTN = 2'b10,
    PAD_NONE = 2'b11
  } pad_type_e;

  pad_type_e          pad_type;
  pad_type_e          type_q;
  logic               th_q;
  logic [1:0]         cnt;
  logic [TIMER_W-1:0] timer;

  logic               th_fall;
  logic               type_changed;
  logic               expired;
  logic [1:0]         cnt_next;
  logic [1:0]         cnt_prev;
  logic [TIMER_W-1:0] timer_next;
  logic [2:0]         six_phase;
  logic [2:0]         phase_next;
  logic [5:0]         data_next;
  logic [5:0]         map_th_high;
  logic [5:0]         map_th_low;

  logic btn_z, btn_y, btn_x, btn_m, btn_s, btn_c;
  logic btn_b, btn_a, btn_u, btn_d, btn_l, btn_r;

  assign pad_type = pad_type_e'(iPAD_TYPE);

  assign {btn_z, btn_y, btn_x, btn_m, btn_s, btn_c,
          btn_b, btn_a, btn_u, btn_d, btn_l, btn_r} = iBUTTONS;

  // The two standard 3-button views of the pad. With TH low, Left and Right
  // are forced to read as pressed: that is how the console recognises a
  // 3-button (or better) pad.
  assign map_th_high = ~{btn_c, btn_b, btn_u, btn_d, btn_l, btn_r};
  assign map_th_low  = ~{btn_s, btn_a, btn_u, btn_d, 1'b1, 1'b1};

  // Sequence counter and timeout bookkeeping. A type change restarts the
  // sequence outright; otherwise a TH falling edge beats a simultaneous
  // timeout expiry. Expiry fires only on the cycle the timer passes
  // TIMEOUT_CYCLES-1, and the timer then parks at TIMEOUT_CYCLES so it
  // cannot fire again until the next falling edge.
  always_comb begin
    th_fall      = th_q & ~iTH;
    type_changed = (pad_type != type_q);
    expired      = (timer == TIMER_LAST);
    cnt_next     = cnt;
    timer_next   = timer;

    if (type_changed) begin
      cnt_next   = 2'd0;
      timer_next = '0;
    end else if (th_fall) begin
      cnt_next   = cnt + 2'd1;
      timer_next = '0;
    end else begin
      if (expired) begin
        cnt_next = iTH ? 2'd0 : 2'd1;
      end
      if (timer != TIMER_MAX) begin
        timer_next = timer + 1'b1;
      end
    end

    // Only the 6-button protocol walks through the sequence.
    if (pad_type != PAD_6BTN) begin
      cnt_next = 2'd0;
    end
  end

  // Protocol state and data-line selection, both taken from the updated
  // counter and the live TH level so the registered outputs track an input
  // change one clock later. With TH low the state is odd and trails the
  // counter by one edge, so counter 0 (just wrapped) lands on state 7.
  always_comb begin
    cnt_prev  = cnt_next - 2'd1;
    six_phase = iTH ? {cnt_next, 1'b0} : {cnt_prev, 1'b1};

    phase_next = 3'd0;
    data_next  = 6'h3F;

    case (pad_type)
      PAD_SMS: begin
        phase_next = 3'd0;
        data_next  = map_th_high;
      end
      PAD_3BTN: begin
        phase_next = iTH ? 3'd0 : 3'd1;
        data_next  = iTH ? map_th_high : map_th_low;
      end
      PAD_6BTN: begin
        phase_next = six_phase;
        case (six_phase)
          3'd0, 3'd2, 3'd4: data_next = map_th_high;
          3'd1, 3'd3:       data_next = map_th_low;
          3'd5:             data_next = ~{btn_s, btn_a, 4'b1111};
          3'd6:             data_next = ~{2'b00, btn_z, btn_y, btn_x, btn_m};
          default:          data_next = ~{btn_s, btn_a, 4'b0000};
        endcase
      end
      default: begin
        phase_next = 3'd0;
        data_next  = 6'h3F;
      end
    endcase
  end

  // All protocol state and both outputs. TH history resets high so a TH
  // held low through reset only counts as an edge if it is still low on the
  // first cycle after release.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      th_q      <= 1'b1;
      type_q    <= PAD_NONE;
      cnt       <= 2'd0;
      timer     <= '0;
      oPAD_DATA <= 6'h3F;
      oPHASE    <= 3'd0;
    end else begin
      th_q      <= iTH;
      type_q    <= pad_type;
      cnt       <= cnt_next;
      timer     <= timer_next;
      oPAD_DATA <= data_next;
      oPHASE    <= phase_next;
    end
  end

endmodule

// File: tb/tb_genesis_pad_port.sv
// tb_genesis_pad_port
// Directed testbench for genesis_pad_port. Each task drives one scenario and
// compares the registered outputs against hand-computed values. A short
// timeout is used so the timeout scenarios stay brief.
module tb_genesis_pad_port;

  localparam int TO = 300;

  logic        fpga_clk_50;
  logic        rst_n;
  logic [1:0]  pad_type;
  logic [11:0] buttons;
  logic        th;
  logic [5:0]  pad_data;
  logic [2:0]  phase;

  int passed;
  int total;

  genesis_pad_port #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .iCLK      (fpga_clk_50),
    .iRST_N    (rst_n),
    .iPAD_TYPE (pad_type),
    .iBUTTONS  (buttons),
    .iTH       (th),
    .oPAD_DATA (pad_data),
    .oPHASE    (phase)
  );

  initial fpga_clk_50 = 1'b0;
  always #5 fpga_clk_50 = ~fpga_clk_50;

  // Advance one clock; outputs are read 1 ns after the rising edge and
  // inputs are changed at the same point.
  task automatic tick();
    @(posedge fpga_clk_50);
    #1;
  endtask

  task automatic th_level(input logic v, input int n);
    th = v;
    repeat (n) tick();
  endtask

  // Restart the 6-button sequence through a type change with TH high.
  task automatic start_six();
    th = 1'b1;
    pad_type = 2'b01;
    tick();
    pad_type = 2'b10;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pad_type = 2'b11;
    buttons = 12'h000;
    th = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({pad_data, phase} !== {6'h3F, 3'd0})
        $display("[TB] FAIL reset_hold[%0d]: got data=%b phase=%0d, want data=111111 phase=0", i, pad_data, phase);
      else passed++;
      th = ~th;
    end
    rst_n = 1'b1;
    th = 1'b1;
    tick();
    total++;
    if ({pad_data, phase} !== {6'h3F, 3'd0})
      $display("[TB] FAIL reset_release: got data=%b phase=%0d, want data=111111 phase=0", pad_data, phase);
    else passed++;
  endtask

  task automatic test_master_system();
    pad_type = 2'b00;
    buttons = 12'h061;
    th = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      total++;
      if ({pad_data, phase} !== {6'b001110, 3'd0})
        $display("[TB] FAIL sms[%0d]: got data=%b phase=%0d, want data=001110 phase=0", i, pad_data, phase);
      else passed++;
      if (i % 2 == 1) th = ~th;
      tick();
    end
  endtask

  task automatic test_three_button();
    logic [5:0] exp_d;
    logic [2:0] exp_p;
    pad_type = 2'b01;
    buttons = 12'h098;
    th = 1'b1;
    tick();
    total++;
    if ({pad_data, phase} !== {6'b110111, 3'd0})
      $display("[TB] FAIL three_th_high: got data=%b phase=%0d, want data=110111 phase=0", pad_data, phase);
    else passed++;
    th = 1'b0;
    #1;
    total++;
    if (pad_data !== 6'b110111)
      $display("[TB] FAIL three_latency_hold: got data=%b, want data=110111", pad_data);
    else passed++;
    tick();
    total++;
    if ({pad_data, phase} !== {6'b000100, 3'd1})
      $display("[TB] FAIL three_th_low: got data=%b phase=%0d, want data=000100 phase=1", pad_data, phase);
    else passed++;
    th_level(1'b1, 2);
    for (int p = 0; p < 4; p++) begin
      for (int lvl = 0; lvl < 2; lvl++) begin
        th = (lvl == 0) ? 1'b0 : 1'b1;
        exp_d = th ? 6'b110111 : 6'b000100;
        exp_p = th ? 3'd0 : 3'd1;
        repeat (2) begin
          tick();
          total++;
          if ({pad_data, phase} !== {exp_d, exp_p})
            $display("[TB] FAIL three_pulse[%0d]: got data=%b phase=%0d, want data=%b phase=%0d", p, pad_data, phase, exp_d, exp_p);
          else passed++;
        end
      end
    end
  endtask

  task automatic test_six_button();
    logic [5:0] exp_data [8];
    logic [2:0] exp_p;
    exp_data = '{6'b111111, 6'b111100, 6'b111111, 6'b111100,
                 6'b111111, 6'b110000, 6'b110110, 6'b111111};
    buttons = 12'h900;
    th = 1'b1;
    pad_type = 2'b10;
    tick();
    total++;
    if ({pad_data, phase} !== {6'b111111, 3'd0})
      $display("[TB] FAIL six_entry: got data=%b phase=%0d, want data=111111 phase=0", pad_data, phase);
    else passed++;
    repeat (9) tick();
    for (int p = 0; p < 4; p++) begin
      for (int lvl = 0; lvl < 2; lvl++) begin
        th = (lvl == 0) ? 1'b0 : 1'b1;
        exp_p = 3'((2 * p + 1 + lvl) % 8);
        tick();
        total++;
        if ({pad_data, phase} !== {exp_data[exp_p], exp_p})
          $display("[TB] FAIL six_state[%0d]: got data=%b phase=%0d, want data=%b phase=%0d", exp_p, pad_data, phase, exp_data[exp_p], exp_p);
        else passed++;
        repeat (9) tick();
      end
    end
    th = 1'b0;
    tick();
    total++;
    if ({pad_data, phase} !== {6'b111100, 3'd1})
      $display("[TB] FAIL six_fifth_edge: got data=%b phase=%0d, want data=111100 phase=1", pad_data, phase);
    else passed++;
    buttons = 12'h0B0;
    tick();
    total++;
    if ({pad_data, phase} !== {6'b001100, 3'd1})
      $display("[TB] FAIL six_button_change: got data=%b phase=%0d, want data=001100 phase=1", pad_data, phase);
    else passed++;
  endtask

  task automatic test_reset_mid_sequence();
    rst_n = 1'b0;
    tick();
    total++;
    if ({pad_data, phase} !== {6'h3F, 3'd0})
      $display("[TB] FAIL mid_reset: got data=%b phase=%0d, want data=111111 phase=0", pad_data, phase);
    else passed++;
    rst_n = 1'b1;
    buttons = 12'h900;
    th = 1'b1;
    tick();
    total++;
    if ({pad_data, phase} !== {6'b111111, 3'd0})
      $display("[TB] FAIL mid_reset_release: got data=%b phase=%0d, want data=111111 phase=0", pad_data, phase);
    else passed++;
    th_level(1'b1, 2);
    th = 1'b0;
    tick();
    total++;
    if (phase !== 3'd1)
      $display("[TB] FAIL mid_reset_first_edge: got phase=%0d, want phase=1", phase);
    else passed++;
  endtask

  task automatic test_timeout();
    buttons = 12'h900;
    start_six();
    th_level(1'b0, 10);
    th_level(1'b1, 10);
    th = 1'b0;
    tick();
    repeat (9) tick();
    th = 1'b1;
    repeat (TO - 10) tick();
    total++;
    if ({pad_data, phase} !== {6'b111111, 3'd4})
      $display("[TB] FAIL timeout_high_before: got data=%b phase=%0d, want data=111111 phase=4", pad_data, phase);
    else passed++;
    tick();
    total++;
    if ({pad_data, phase} !== {6'b111111, 3'd0})
      $display("[TB] FAIL timeout_high_expire: got data=%b phase=%0d, want data=111111 phase=0", pad_data, phase);
    else passed++;
    repeat (5) tick();
    total++;
    if (phase !== 3'd0)
      $display("[TB] FAIL timeout_saturated: got phase=%0d, want phase=0", phase);
    else passed++;

    th_level(1'b0, 10);
    th_level(1'b1, 10);
    th_level(1'b0, 10);
    th_level(1'b1, 10);
    th = 1'b0;
    tick();
    total++;
    if ({pad_data, phase} !== {6'b110000, 3'd5})
      $display("[TB] FAIL timeout_low_state5: got data=%b phase=%0d, want data=110000 phase=5", pad_data, phase);
    else passed++;
    repeat (TO - 1) tick();
    total++;
    if (phase !== 3'd5)
      $display("[TB] FAIL timeout_low_before: got phase=%0d, want phase=5", phase);
    else passed++;
    tick();
    total++;
    if ({pad_data, phase} !== {6'b111100, 3'd1})
      $display("[TB] FAIL timeout_low_expire: got data=%b phase=%0d, want data=111100 phase=1", pad_data, phase);
    else passed++;
  endtask

  task automatic test_edge_on_expiry();
    buttons = 12'h900;
    start_six();
    th_level(1'b0, 10);
    th_level(1'b1, 10);
    th = 1'b0;
    tick();
    repeat (9) tick();
    th = 1'b1;
    repeat (TO - 10) tick();
    th = 1'b0;
    tick();
    total++;
    if ({pad_data, phase} !== {6'b110000, 3'd5})
      $display("[TB] FAIL edge_on_expiry: got data=%b phase=%0d, want data=110000 phase=5", pad_data, phase);
    else passed++;
    repeat (TO - 1) tick();
    total++;
    if (phase !== 3'd5)
      $display("[TB] FAIL edge_cleared_timer: got phase=%0d, want phase=5", phase);
    else passed++;
    tick();
    total++;
    if (phase !== 3'd1)
      $display("[TB] FAIL edge_then_expire: got phase=%0d, want phase=1", phase);
    else passed++;
  endtask

  task automatic test_type_change();
    buttons = 12'h900;
    start_six();
    th_level(1'b0, 10);
    th_level(1'b1, 10);
    th_level(1'b0, 10);
    th_level(1'b1, 10);
    th = 1'b0;
    tick();
    total++;
    if (phase !== 3'd5)
      $display("[TB] FAIL type_change_pre: got phase=%0d, want phase=5", phase);
    else passed++;
    pad_type = 2'b01;
    tick();
    total++;
    if ({pad_data, phase} !== {6'b111100, 3'd1})
      $display("[TB] FAIL type_change_10_to_01: got data=%b phase=%0d, want data=111100 phase=1", pad_data, phase);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    rst_n = 1'b0;
    pad_type = 2'b11;
    buttons = 12'h000;
    th = 1'b1;
    #1;
    test_reset();
    test_master_system();
    test_three_button();
    test_six_button();
    test_reset_mid_sequence();
    test_timeout();
    test_edge_on_expiry();
    test_type_change();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
